// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a show-ahead FIFO in bursts onto a valid/ready
// stream. A burst starts when a full BURST_LEN is available, on a flush
// request, or after the FIFO has sat non-empty for TIMEOUT cycles.
//
//   state | meaning
//   IDLE  | waiting for a start condition; idle timer running
//   BURST | popping words; remaining counts words still to pop
//   DONE  | last word popped, waiting for its beat to transfer
module fifo_burst_reader #(
  parameter int DSIZE     = 16,
  parameter int ASIZE     = 16,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty_i,
  input  logic [DSIZE-1:0] fifo_rd_data_i,
  input  logic [ASIZE:0]   fifo_counter_i,
  output logic             fifo_rd_en_o,
  input  logic             flush_i,
  output logic             m_valid_o,
  output logic [DSIZE-1:0] m_data_o,
  output logic             m_last_o,
  input  logic             m_ready_i,
  output logic             burst_done_o,
  output logic             busy_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TIMEOUT_C   = TW'(TIMEOUT);
  localparam logic [ASIZE:0] BURST_LEN_C = (ASIZE + 1)'(BURST_LEN);
  localparam logic [ASIZE:0] CNT_ONE     = {{ASIZE{1'b0}}, 1'b1};
  localparam logic [ASIZE:0] CNT_ZERO    = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [TW-1:0]   timer_q;
  logic [ASIZE:0]  remaining_q;
  logic [ASIZE:0]  start_len;
  logic            start;
  logic            pop;
  logic            beat;

  assign beat         = m_valid_o && m_ready_i;
  assign fifo_rd_en_o = pop;
  assign busy_o       = (state_q != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, start decision and pop qualification.
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    start_len = CNT_ZERO;
    // Pop only when the output register is free or being drained this cycle.
    pop       = (state_q == BURST) && !fifo_empty_i && (!m_valid_o || m_ready_i);
    case (state_q)
      IDLE: begin
        if (fifo_counter_i >= BURST_LEN_C) begin
          start     = 1'b1;
          start_len = BURST_LEN_C;
        end else if ((fifo_counter_i != CNT_ZERO) &&
                     (flush_i || (timer_q == TIMEOUT_C))) begin
          start     = 1'b1;
          start_len = fifo_counter_i;
        end
        if (start) state_d = BURST;
      end
      BURST: begin
        if (pop && (remaining_q == CNT_ONE)) state_d = DONE;
      end
      DONE: begin
        if (beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Idle timer: counts non-empty IDLE cycles, saturates, clears otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if ((state_q == IDLE) && !start && !fifo_empty_i) begin
      if (timer_q != TIMEOUT_C) timer_q <= timer_q + 1'b1;
    end else begin
      timer_q <= '0;
    end
  end

  // Words still to pop in the current burst; fixed at start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     remaining_q <= '0;
    else if (start) remaining_q <= start_len;
    else if (pop)   remaining_q <= remaining_q - 1'b1;
  end

  // Output register: loads on pop, holds under backpressure, empties on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_last_o  <= 1'b0;
    end else if (pop) begin
      m_valid_o <= 1'b1;
      m_data_o  <= fifo_rd_data_i;
      m_last_o  <= (remaining_q == CNT_ONE);
    end else if (beat) begin
      m_valid_o <= 1'b0;
      m_last_o  <= 1'b0;
    end
  end

  // One-cycle pulse after the final beat of a burst transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) burst_done_o <= 1'b0;
    else        burst_done_o <= (state_q == DONE) && beat;
  end

endmodule
